final_adder: RTL and testbench

Pipelined carry-propagate adder that sits directly downstream of the multiplier compressor tree. It takes the two redundant rows (`sum`, `carry`) and resolves them into the binary product. The addition is split into a low segment and a high segment across two register stages, with a registered carry between them. A valid/ready handshake with full backpressure connects it to the product consumer.

---
 rtl/mult_pkg.sv | 23 ++
 rtl/cpa_segment.sv | 22 ++
 rtl/final_adder.sv | 114 +++++++++++
 tb/tb_final_adder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared types and widths for the multiplier datapath.
//   OP_W      - multiplier operand width
//   PROD_W    - product / compressor-tree row width (2 x OP_W)
//   prod_t    - product-width vector
//   stage_a_t - first final-adder stage contents for the default split
//               (low result, segment carry, untouched high operand slices)
package mult_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 2 * OP_W;
  localparam int LO_DEF = PROD_W / 2;
  localparam int HI_DEF = PROD_W - LO_DEF;

  typedef logic [PROD_W-1:0] prod_t;

  typedef struct packed {
    logic [LO_DEF-1:0] lo;
    logic              cy;
    logic [HI_DEF-1:0] sum_hi;
    logic [HI_DEF-1:0] carry_hi;
  } stage_a_t;

endpackage

// File: rtl/cpa_segment.sv
// cpa_segment: combinational W-bit ripple adder with carry in/out.
//   i_a, i_b : W-bit addends
//   i_cin    : carry into bit 0
//   o_sum    : W-bit sum
//   o_cout   : carry out of bit W-1
module cpa_segment #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic [W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
  assign o_sum  = w_full[W-1:0];
  assign o_cout = w_full[W];

endmodule

// File: rtl/final_adder.sv
// final_adder: two-stage pipelined carry-propagate adder resolving the
// compressor tree's sum/carry rows into the binary product.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake (in_ready is combinational)
//   sum, carry           : redundant rows, both already weight-aligned
//   out_valid / out_ready: output handshake
//   product              : (sum + carry) mod 2^WIDTH, registered
//   overflow             : carry out of bit WIDTH-1 (upstream fault flag)
// Stage A adds the low LO_W bits and parks the high operand slices; stage B
// adds the high slices plus the registered low carry. Each stage is one
// short ripple segment.
import mult_pkg::*;

module final_adder #(
  parameter int WIDTH = PROD_W,
  parameter int LO_W  = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum,
  input  logic [WIDTH-1:0] carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] product,
  output logic             overflow
);

  localparam int HI_W = WIDTH - LO_W;

  // Stage A registers
  logic            r_a_valid;
  logic [LO_W-1:0] r_a_lo;
  logic            r_a_cy;
  logic [HI_W-1:0] r_a_sum_hi;
  logic [HI_W-1:0] r_a_carry_hi;

  // Stage B registers (drive the outputs directly)
  logic             r_b_valid;
  logic [WIDTH-1:0] r_product;
  logic             r_overflow;

  logic            w_b_adv;
  logic            w_a_adv;
  logic            w_accept;
  logic            w_a_to_b;
  logic [LO_W-1:0] w_lo_sum;
  logic            w_lo_cout;
  logic [HI_W-1:0] w_hi_sum;
  logic            w_hi_cout;

  // A stage may advance when it is empty or its successor advances; a full
  // pipeline therefore passes out_ready straight through to in_ready.
  assign w_b_adv  = !r_b_valid || out_ready;
  assign w_a_adv  = !r_a_valid || w_b_adv;
  assign in_ready = w_a_adv && !rst;
  assign w_accept = in_valid && in_ready;
  assign w_a_to_b = r_a_valid && w_b_adv;

  cpa_segment #(.W(LO_W)) u_lo (
    .i_a    (sum[LO_W-1:0]),
    .i_b    (carry[LO_W-1:0]),
    .i_cin  (1'b0),
    .o_sum  (w_lo_sum),
    .o_cout (w_lo_cout)
  );

  cpa_segment #(.W(HI_W)) u_hi (
    .i_a    (r_a_sum_hi),
    .i_b    (r_a_carry_hi),
    .i_cin  (r_a_cy),
    .o_sum  (w_hi_sum),
    .o_cout (w_hi_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_valid    <= 1'b0;
      r_a_lo       <= '0;
      r_a_cy       <= 1'b0;
      r_a_sum_hi   <= '0;
      r_a_carry_hi <= '0;
    end else if (w_accept) begin
      // New item overwrites whatever is being handed to B this cycle.
      r_a_valid    <= 1'b1;
      r_a_lo       <= w_lo_sum;
      r_a_cy       <= w_lo_cout;
      r_a_sum_hi   <= sum[WIDTH-1:LO_W];
      r_a_carry_hi <= carry[WIDTH-1:LO_W];
    end else if (w_b_adv) begin
      r_a_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_b_valid  <= 1'b0;
      r_product  <= '0;
      r_overflow <= 1'b0;
    end else if (w_a_to_b) begin
      r_b_valid  <= 1'b1;
      r_product  <= {w_hi_sum, r_a_lo};
      r_overflow <= w_hi_cout;
    end else if (out_ready) begin
      r_b_valid  <= 1'b0;
    end
  end

  assign out_valid = r_b_valid;
  assign product   = r_product;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_final_adder.sv
module tb_final_adder;
  import mult_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] sum;
  logic [W-1:0] carry;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] product;
  logic         overflow;

  int n_cmp = 0;
  int n_bad = 0;

  final_adder #(.WIDTH(W), .LO_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .carry     (carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic [W-1:0] c;
    logic [W-1:0] exp_p;
    logic         exp_o;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  logic [W-1:0] rs [16];
  logic [W-1:0] rc [16];
  logic [W:0]   rexp;

  initial begin
    vecs[0] = '{8'h5A, 8'h35, 8'h8F, 1'b0};
    vecs[1] = '{8'h0F, 8'h01, 8'h10, 1'b0};
    vecs[2] = '{8'hF0, 8'h20, 8'h10, 1'b1};
    vecs[3] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[5] = '{8'h7F, 8'h80, 8'hFF, 1'b0};
    vecs[6] = '{8'h08, 8'h08, 8'h10, 1'b0};
    vecs[7] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[8] = '{8'h0A, 8'h05, 8'h0F, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sum = '0; carry = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_product", product, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", in_ready, 1);

    // Single items, two-cycle latency, one-cycle output pulse
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      sum = vecs[i].s; carry = vecs[i].c; in_valid = 1'b1;
      #1 chk("vec_in_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0; sum = 8'($urandom); carry = 8'($urandom);
      chk("vec_lat1_valid", out_valid, 0);
      @(negedge clk);
      chk("vec_valid", out_valid, 1);
      chk("vec_product", product, vecs[i].exp_p);
      chk("vec_overflow", overflow, vecs[i].exp_o);
      @(negedge clk);
      chk("vec_pulse_end", out_valid, 0);
    end

    // Backpressure: 3 items offered, only 2 fit
    out_ready = 1'b0;
    sum = 8'h01; carry = 8'h01; in_valid = 1'b1;
    #1 chk("bp_rdy0", in_ready, 1);
    @(negedge clk);
    sum = 8'h02; carry = 8'h02;
    #1 chk("bp_rdy1", in_ready, 1);
    @(negedge clk);
    sum = 8'h03; carry = 8'h03;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_full_rdy", in_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_prod", product, 8'h02);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_passthru_rdy", in_ready, 1);
    chk("bp_out0", product, 8'h02);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_v1", out_valid, 1);
    chk("bp_out1", product, 8'h04);
    @(negedge clk);
    chk("bp_v2", out_valid, 1);
    chk("bp_out2", product, 8'h06);
    @(negedge clk);
    chk("bp_drained", out_valid, 0);

    // Full throughput: 16 back-to-back items
    for (int i = 0; i < 16; i++) begin
      rs[i] = 8'($urandom);
      rc[i] = 8'($urandom);
    end
    for (int cyc = 0; cyc < 19; cyc++) begin
      if (cyc >= 2 && cyc < 18) begin
        rexp = {1'b0, rs[cyc-2]} + {1'b0, rc[cyc-2]};
        chk("tp_valid", out_valid, 1);
        chk("tp_product", product, rexp[W-1:0]);
        chk("tp_overflow", overflow, rexp[W]);
      end else begin
        chk("tp_idle", out_valid, 0);
      end
      if (cyc < 16) begin
        in_valid = 1'b1; sum = rs[cyc]; carry = rc[cyc];
        #1 chk("tp_in_ready", in_ready, 1);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end

    // Reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1; sum = 8'h11; carry = 8'h22;
    @(negedge clk);
    sum = 8'h33; carry = 8'h44;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rm_full_valid", out_valid, 1);
    chk("rm_full_prod", product, 8'h33);
    rst = 1'b1;
    #1 chk("rm_rst_rdy", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("rm_out_valid", out_valid, 0);
    chk("rm_product", product, 0);
    chk("rm_overflow", overflow, 0);
    #1 chk("rm_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rm_no_stale", out_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
